rtc_access_sched: RTL

Access scheduler that sequences the V3023 RTC bus-transfer engine. It keeps a snapshot of the RTC time registers coherent by re-reading them at a fixed period. It accepts one-at-a-time register write requests from the user-interface logic and serializes them with the refresh reads. It drives the engine's access/read controls plus the multiplexed address/data values, and uses the engine's finished pulse to advance.

---
 rtl/rtc_access_sched.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rtc_access_sched.sv
// Access scheduler for the V3023 RTC transfer engine: periodic time-register refresh
// bursts serialized with a one-deep write buffer. Optional watchdog: RTC_SCHED_TIMEOUT_EN.
module rtc_access_sched #(
  parameter int         N_REGS         = 6,
  parameter logic [7:0] BASE_ADDR      = 8'h21,
  parameter int         REFRESH_CYCLES = 1000000,
  parameter int         ACC_HOLD       = 4,
  parameter int         TIMEOUT        = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_req,
  input  logic [7:0]          wr_addr,
  input  logic [7:0]          wr_data,
  output logic                wr_busy,
  output logic                wr_ack,
  input  logic                refresh_now,
  output logic [8*N_REGS-1:0] time_regs,
  output logic                time_valid,
  output logic                err,
  input  logic                err_clr,
  output logic                xfer_acc,
  output logic                xfer_read,
  output logic [7:0]          xfer_addr,
  output logic [7:0]          xfer_wdata,
  input  logic [7:0]          xfer_rdata,
  input  logic                xfer_done
);

  localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int CNT_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int HOLD_W = (ACC_HOLD > 1) ? $clog2(ACC_HOLD) : 1;
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_REGS - 1);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ACC_HOLD - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RECOV = 2'd3;

  logic [1:0]          state_q, state_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                acc_q, acc_d;
  logic                read_q, read_d;
  logic [7:0]          addr_q, addr_d;
  logic [7:0]          wdata_q, wdata_d;
  logic [8*N_REGS-1:0] shadow_q, shadow_d;
  logic [8*N_REGS-1:0] time_regs_q, time_regs_d;
  logic                time_valid_q, time_valid_d;
  logic                wr_ack_q, wr_ack_d;
  logic                buf_valid_q, buf_valid_d;
  logic [7:0]          buf_addr_q, buf_addr_d;
  logic [7:0]          buf_data_q, buf_data_d;
  logic                pend_q, pend_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q;
  logic                done_rise_s;
  logic                pend_set_s;
  logic                pend_clr_s;

`ifdef RTC_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            err_q, err_d;
  logic            err_set_s;
`endif

  // Next-state logic: refresh timer, write buffer, transfer sequencer, watchdog
  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    read_d       = read_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    shadow_d     = shadow_q;
    time_regs_d  = time_regs_q;
    time_valid_d = 1'b0;
    wr_ack_d     = 1'b0;
    buf_addr_d   = buf_addr_q;
    buf_data_d   = buf_data_q;
    pend_clr_s   = 1'b0;
    done_rise_s  = xfer_done & ~done_q;

    if (cnt_q == '0) begin
      cnt_d      = CNT_RELOAD;
      pend_set_s = 1'b1;
    end else begin
      cnt_d      = cnt_q - CNT_W'(1);
      pend_set_s = refresh_now;
    end

    if (wr_req && !buf_valid_q) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = wr_addr;
      buf_data_d  = wr_data;
    end else begin
      buf_valid_d = buf_valid_q;
    end

    case (state_q)
      S_IDLE: begin
        // A buffered write always beats a pending refresh
        if (buf_valid_q) begin
          state_d = S_REQ;
          acc_d   = 1'b1;
          hold_d  = '0;
          read_d  = 1'b0;
          addr_d  = buf_addr_q;
          wdata_d = buf_data_q;
        end else if (pend_q) begin
          pend_clr_s = 1'b1;
          state_d    = S_REQ;
          acc_d      = 1'b1;
          hold_d     = '0;
          idx_d      = '0;
          read_d     = 1'b1;
          addr_d     = BASE_ADDR;
        end else begin
          acc_d = 1'b0;
        end
      end
      S_REQ: begin
        if (hold_q == HOLD_LAST) begin
          acc_d   = 1'b0;
          state_d = S_WAIT;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      S_WAIT: begin
        if (done_rise_s) begin
          if (read_q) begin
            shadow_d[32'(idx_q) * 32'd8 +: 8] = xfer_rdata;
          end else begin
            shadow_d = shadow_q;
          end
          state_d = S_RECOV;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_RECOV: begin
        if (!xfer_done) begin
          if (!read_q) begin
            wr_ack_d    = 1'b1;
            buf_valid_d = 1'b0;
            state_d     = S_IDLE;
          end else if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + IDX_W'(1);
            addr_d  = BASE_ADDR + 8'(idx_q) + 8'd1;
            acc_d   = 1'b1;
            hold_d  = '0;
            state_d = S_REQ;
          end else begin
            time_regs_d  = shadow_q;
            time_valid_d = 1'b1;
            state_d      = S_IDLE;
          end
        end else begin
          state_d = S_RECOV;
        end
      end
      default: begin
        state_d = S_IDLE;
        acc_d   = 1'b0;
      end
    endcase

`ifdef RTC_SCHED_TIMEOUT_EN
    err_set_s = 1'b0;
    if (state_q != S_REQ && state_d == S_REQ) begin
      wd_d = '0;
    end else if (state_q == S_REQ || state_q == S_WAIT) begin
      wd_d = wd_q + WD_W'(1);
    end else begin
      wd_d = wd_q;
    end
    // Abort: drop the transfer, the buffered write or the partial shadow
    if ((state_q == S_REQ || (state_q == S_WAIT && !done_rise_s)) && wd_q == WD_LAST) begin
      err_set_s = 1'b1;
      state_d   = S_IDLE;
      acc_d     = 1'b0;
      if (!read_q) begin
        buf_valid_d = 1'b0;
      end else begin
        idx_d = '0;
      end
    end else begin
      err_set_s = 1'b0;
    end
    err_d = err_set_s | (err_q & ~err_clr);
`endif

    pend_d = pend_set_s | (pend_q & ~pend_clr_s);
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      idx_q        <= '0;
      acc_q        <= 1'b0;
      read_q       <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      shadow_q     <= '0;
      time_regs_q  <= '0;
      time_valid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      buf_valid_q  <= 1'b0;
      buf_addr_q   <= 8'h00;
      buf_data_q   <= 8'h00;
      pend_q       <= 1'b0;
      cnt_q        <= CNT_RELOAD;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      read_q       <= read_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      shadow_q     <= shadow_d;
      time_regs_q  <= time_regs_d;
      time_valid_q <= time_valid_d;
      wr_ack_q     <= wr_ack_d;
      buf_valid_q  <= buf_valid_d;
      buf_addr_q   <= buf_addr_d;
      buf_data_q   <= buf_data_d;
      pend_q       <= pend_d;
      cnt_q        <= cnt_d;
      done_q       <= xfer_done;
    end
  end

`ifdef RTC_SCHED_TIMEOUT_EN
  // Watchdog counter and sticky error flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  logic unused_s;
  assign unused_s = err_clr | (TIMEOUT < 0);
  assign err      = 1'b0;
`endif

  assign wr_busy    = buf_valid_q;
  assign wr_ack     = wr_ack_q;
  assign time_regs  = time_regs_q;
  assign time_valid = time_valid_q;
  assign xfer_acc   = acc_q;
  assign xfer_read  = read_q;
  assign xfer_addr  = addr_q;
  assign xfer_wdata = wdata_q;

endmodule
